// File: rtl/fibonacci_pkg.sv
// Shared types and helpers for the fibonacci sequence checker.
package fibonacci_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  // Widest value bus the sum helper supports; narrower buses are zero-extended.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2
  } fib_state_t;

  // Full-precision sum of the two previous terms; the top bit is the wrap carry.
  function automatic logic [MAX_WIDTH:0] fib_sum(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/fibonacci_checker_sat_counter.sv
// Saturating up-counter used for the match and error tallies.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fibonacci_checker.sv
// Receive-side fibonacci checker: every accepted term must equal the sum of
// the two before it (mod 2^WIDTH). Mismatches resynchronise automatically.
// Optional macro FIB_STRICT_SEED_EN forces the seeds to be exactly 0 then 1,
// and makes every error restart from the first seed.
module fibonacci_checker
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] value,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             wrapped,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  fib_state_t       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   exp_sum;
  logic             match_inc;
  logic             err_inc;

  assign exp_sum = (WIDTH+1)'(fib_sum(MAX_WIDTH'(a), MAX_WIDTH'(b)));

  // Classify the current sample as a verified term, an error, or neither.
  always_comb begin
    match_inc = 1'b0;
    err_inc   = 1'b0;
    if (valid) begin
      case (state)
        TRACK: begin
          if (value == exp_sum[WIDTH-1:0]) begin
            match_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
`ifdef FIB_STRICT_SEED_EN
        SEED0:   err_inc = (value != '0);
        SEED1:   err_inc = (value != WIDTH'(1));
`endif
        default: ;
      endcase
    end
  end

  // Sequence tracker: seeds a and b, then slides the window on every good term.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEED0;
      a          <= '0;
      b          <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (valid) begin
        if (err_inc) begin
          err_pulse  <= 1'b1;
          err_sticky <= 1'b1;
        end
        case (state)
          SEED0: begin
            if (!err_inc) begin
              a     <= value;
              state <= SEED1;
            end
          end
          SEED1: begin
            if (!err_inc) begin
              b      <= value;
              state  <= TRACK;
              locked <= 1'b1;
            end else begin
              state  <= SEED0;
              locked <= 1'b0;
            end
          end
          TRACK: begin
            if (match_inc) begin
              a <= b;
              b <= value;
              if (exp_sum[WIDTH]) begin
                wrapped <= 1'b1;
              end
            end else begin
`ifdef FIB_STRICT_SEED_EN
              state <= SEED0;
`else
              a     <= value;
              state <= SEED1;
`endif
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEED0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_inc),
    .count (match_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_fibonacci_checker.sv
// Testbench for fibonacci_checker: directed vector table, hand sequences for
// the wrap/saturation/strict-seed corners, and randomized stimulus against a
// queue-based reference model. Two instances: 32/16 and 8/2 bit.
module tb_fibonacci_checker;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] val;
    logic        l;
    logic        p;
    logic        s;
    logic        w;
    int          m;
    int          e;
  } vec_t;

  localparam int     WDT  [2] = '{32, 8};
  localparam longint CMAX [2] = '{65535, 3};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] value = '0;

  logic        locked32, pulse32, sticky32, wrapped32;
  logic [15:0] match32, err32;
  logic        locked8, pulse8, sticky8, wrapped8;
  logic [1:0]  match8, err8;

  int checks = 0;
  int failures = 0;

  longint hist [2][$];
  longint mcnt [2];
  longint ecnt [2];
  bit     sticky [2];
  bit     wrapf [2];
  bit     pulse [2];

  vec_t vecs[$];

  always #5 clk = ~clk;

  fibonacci_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .value       (value),
    .locked      (locked32),
    .err_pulse   (pulse32),
    .err_sticky  (sticky32),
    .wrapped     (wrapped32),
    .match_count (match32),
    .err_count   (err32)
  );

  fibonacci_checker #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .value       (value[7:0]),
    .locked      (locked8),
    .err_pulse   (pulse8),
    .err_sticky  (sticky8),
    .wrapped     (wrapped8),
    .match_count (match8),
    .err_count   (err8)
  );

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a window of accepted terms since the last (re)sync.
  task automatic model_step(input logic rst, input logic v, input logic [31:0] val);
    for (int k = 0; k < 2; k++) begin
      longint md;
      longint x;
      longint s;
      bit     bad;
      md  = longint'(1) << WDT[k];
      x   = longint'(val) % md;
      bad = 1'b0;
      pulse[k] = 1'b0;
      if (rst) begin
        hist[k].delete();
        mcnt[k] = 0;
        ecnt[k] = 0;
        sticky[k] = 1'b0;
        wrapf[k] = 1'b0;
      end else if (v) begin
        if (hist[k].size() >= 2) begin
          s = hist[k][hist[k].size()-2] + hist[k][hist[k].size()-1];
          if (x == s % md) begin
            if (mcnt[k] < CMAX[k]) mcnt[k]++;
            if (s >= md) wrapf[k] = 1'b1;
            hist[k].push_back(x);
            if (hist[k].size() > 2) void'(hist[k].pop_front());
          end else begin
            bad = 1'b1;
            hist[k].delete();
`ifndef FIB_STRICT_SEED_EN
            hist[k].push_back(x);
`endif
          end
        end else begin
`ifdef FIB_STRICT_SEED_EN
          if (x != longint'(hist[k].size())) begin
            bad = 1'b1;
            hist[k].delete();
          end else begin
            hist[k].push_back(x);
          end
`else
          hist[k].push_back(x);
`endif
        end
        if (bad) begin
          pulse[k] = 1'b1;
          sticky[k] = 1'b1;
          if (ecnt[k] < CMAX[k]) ecnt[k]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] val);
    @(negedge clk);
    reset = rst;
    valid = v;
    value = val;
    @(posedge clk);
    #1;
    model_step(rst, v, val);
  endtask

  task automatic checkOutput();
    check_val("d32.locked",  locked32,  hist[0].size() >= 2);
    check_val("d32.pulse",   pulse32,   pulse[0]);
    check_val("d32.sticky",  sticky32,  sticky[0]);
    check_val("d32.wrapped", wrapped32, wrapf[0]);
    check_val("d32.match",   match32,   mcnt[0]);
    check_val("d32.err",     err32,     ecnt[0]);
    check_val("d8.locked",   locked8,   hist[1].size() >= 2);
    check_val("d8.pulse",    pulse8,    pulse[1]);
    check_val("d8.sticky",   sticky8,   sticky[1]);
    check_val("d8.wrapped",  wrapped8,  wrapf[1]);
    check_val("d8.match",    match8,    mcnt[1]);
    check_val("d8.err",      err8,      ecnt[1]);
  endtask

  task automatic add(input logic rst, input logic v, input logic [31:0] val,
                     input logic l, input logic p, input logic s, input logic w,
                     input int m, input int e);
    vec_t t;
    t.rst = rst; t.v = v; t.val = val;
    t.l = l; t.p = p; t.s = s; t.w = w; t.m = m; t.e = e;
    vecs.push_back(t);
  endtask

  task automatic check_vec(input int i, input vec_t t);
    check_val($sformatf("vec%0d.locked", i),  locked32,  t.l);
    check_val($sformatf("vec%0d.pulse", i),   pulse32,   t.p);
    check_val($sformatf("vec%0d.sticky", i),  sticky32,  t.s);
    check_val($sformatf("vec%0d.wrapped", i), wrapped32, t.w);
    check_val($sformatf("vec%0d.match", i),   match32,   t.m);
    check_val($sformatf("vec%0d.err", i),     err32,     t.e);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint fa, fb, fc, nxt;
    int     r;
    logic   rv, rr;
    logic [31:0] rval;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput();

`ifndef FIB_STRICT_SEED_EN
    // Clean sequence 0,1,1,2,3,5,8
    add(1,0,0,  0,0,0,0,0,0);
    add(0,1,0,  0,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,1,0);
    add(0,1,2,  1,0,0,0,2,0);
    add(0,1,3,  1,0,0,0,3,0);
    add(0,1,5,  1,0,0,0,4,0);
    add(0,1,8,  1,0,0,0,5,0);
    // Mismatch on 4 then resync on 4,5 and match 9
    add(1,0,0,  0,0,0,0,0,0);
    add(0,1,0,  0,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,1,0);
    add(0,1,2,  1,0,0,0,2,0);
    add(0,1,4,  0,1,1,0,2,1);
    add(0,1,5,  1,0,1,0,2,1);
    add(0,1,9,  1,0,1,0,3,1);
    // valid toggling leaves state untouched on low cycles
    add(1,0,0,  0,0,0,0,0,0);
    add(0,1,0,  0,0,0,0,0,0);
    add(0,0,77, 0,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,0,0);
    add(0,0,123,1,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,1,0);
    add(0,0,9,  1,0,0,0,1,0);
    add(0,1,2,  1,0,0,0,2,0);
    add(0,0,0,  1,0,0,0,2,0);
    // Ten good terms, reset mid-sequence, restart on 3,5,8
    add(1,0,0,  0,0,0,0,0,0);
    add(0,1,0,  0,0,0,0,0,0);
    add(0,1,1,  1,0,0,0,0,0);
    fa = 0; fb = 1;
    for (int i = 1; i <= 10; i++) begin
      fc = fa + fb;
      add(0, 1, fc[31:0], 1, 0, 0, 0, i, 0);
      fa = fb; fb = fc;
    end
    add(1,1,0,  0,0,0,0,0,0);
    add(1,1,7,  0,0,0,0,0,0);
    add(0,1,3,  0,0,0,0,0,0);
    add(0,1,5,  1,0,0,0,0,0);
    add(0,1,8,  1,0,0,0,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].val);
      checkOutput();
      check_vec(i, vecs[i]);
    end

    // 8-bit wrap: 144 + 233 = 377, observed as 121
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd144);
    applyStimulus(1'b0, 1'b1, 32'd233);
    applyStimulus(1'b0, 1'b1, 32'd121);
    checkOutput();
    check_val("wrap8.wrapped", wrapped8, 1);
    check_val("wrap8.err",     err8,     0);
    check_val("wrap8.match",   match8,   1);
    check_val("wrap8.locked",  locked8,  1);
`else
    // Strict seeds: 2,3,5 are all rejected, then 0,1,1 locks
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd2);
    check_val("strict.pulse", pulse32, 1);
    check_val("strict.err1",  err32,   1);
    applyStimulus(1'b0, 1'b1, 32'd3);
    applyStimulus(1'b0, 1'b1, 32'd5);
    check_val("strict.locked0", locked32, 0);
    check_val("strict.err3",    err32,    3);
    applyStimulus(1'b0, 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'd1);
    check_val("strict.locked1", locked32, 1);
    check_val("strict.match",   match32,  1);
    checkOutput();
`endif

    // 2-bit counter saturation: five good terms clamp at 3
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'd2);
    applyStimulus(1'b0, 1'b1, 32'd3);
    applyStimulus(1'b0, 1'b1, 32'd5);
    applyStimulus(1'b0, 1'b1, 32'd8);
    check_val("sat8.match", match8, 3);
    check_val("sat8.err",   err8,   0);
    check_val("sat32.match", match32, 5);
    checkOutput();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (hist[0].size() >= 2)
        nxt = (hist[0][hist[0].size()-2] + hist[0][hist[0].size()-1]) % (longint'(1) << 32);
      else
        nxt = longint'(hist[0].size());
      r = $urandom_range(0, 99);
      if (r < 70)      rval = nxt[31:0];
      else if (r < 85) rval = $urandom;
      else             rval = 32'($urandom_range(0, 3));
      rv = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 99) == 0);
      applyStimulus(rr, rv, rval);
      checkOutput();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
